// File: rtl/scoreboard_register_file_if.sv
// Bus bundle for scoreboard_register_file: operand reads, issue marking,
// writeback and flush. The issue/writeback side (master) drives the strobes
// and addresses. The register file (slave) returns read data, busy flags,
// the stall summary and the busy count.
interface scoreboard_register_file_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREG);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  stall;
  logic                  issue_en;
  logic [AW-1:0]         issue_addr;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  flush;
  logic [AW:0]           busy_count;

  modport master (
    output rd_addr, issue_en, issue_addr, wr_en, wr_addr, wr_data, flush,
    input  rd_data, rd_busy, stall, busy_count
  );

  modport slave (
    input  rd_addr, issue_en, issue_addr, wr_en, wr_addr, wr_data, flush,
    output rd_data, rd_busy, stall, busy_count
  );
endinterface

// File: rtl/scoreboard_register_file.sv
// Integer register file with a per-register busy scoreboard.
// Register 0 reads as zero and is never busy. Issue marks a destination busy.
// Writeback stores data and clears busy. Flush clears all busy bits, but an
// issue in the same cycle still sets its destination busy.
// Optional feature macro: RF_BYPASS_EN. When it is defined, a same-cycle
// writeback is forwarded to matching read ports.
module scoreboard_register_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  scoreboard_register_file_if.slave   bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]       r_regs [NREG];
  logic [NREG-1:0]       r_busy;
  logic [CW-1:0]         r_busy_count;
  logic [NREG-1:0]       w_busy_nxt;
  logic [CW-1:0]         w_busy_cnt_nxt;
  logic [NREAD*XLEN-1:0] w_rd_data;
  logic [NREAD-1:0]      w_rd_busy;

  // Next busy vector with priority issue > flush > writeback; also its popcount
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < NREG; r++) begin
      if (bus.issue_en && (bus.issue_addr == AW'(r)))
        w_busy_nxt[r] = 1'b1;
      else if (bus.flush)
        w_busy_nxt[r] = 1'b0;
      else if (bus.wr_en && (bus.wr_addr == AW'(r)))
        w_busy_nxt[r] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
    w_busy_cnt_nxt = '0;
    for (int r = 0; r < NREG; r++)
      w_busy_cnt_nxt = w_busy_cnt_nxt + CW'(w_busy_nxt[r]);
  end

  // Busy bits and their count share one edge so the count never lags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_cnt_nxt;
    end
  end

  // Register storage; entry 0 is never written so it stays zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++)
        r_regs[r] <= '0;
    end else if (bus.wr_en && (bus.wr_addr != '0)) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = bus.rd_addr[p*AW +: AW];
`ifdef RF_BYPASS_EN
    // Address 0 never hits because wr_addr==0 is excluded from the match
    logic w_hit;
    assign w_hit = bus.wr_en && (bus.wr_addr != '0) && (w_ra == bus.wr_addr);
    assign w_rd_data[p*XLEN +: XLEN] = w_hit ? bus.wr_data : r_regs[w_ra];
    assign w_rd_busy[p] = w_hit ? (bus.issue_en && (bus.issue_addr == bus.wr_addr))
                                : r_busy[w_ra];
`else
    assign w_rd_data[p*XLEN +: XLEN] = r_regs[w_ra];
    assign w_rd_busy[p]              = r_busy[w_ra];
`endif
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.rd_busy    = w_rd_busy;
  assign bus.stall      = |w_rd_busy;
  assign bus.busy_count = r_busy_count;
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench for scoreboard_register_file with XLEN=64, NREG=64 and
// NREAD=3. A behavioural model is checked on every falling edge. Directed
// literal checks cover reset, x0, scoreboard, collision, bypass and the full
// scoreboard fill. These are followed by randomized traffic that includes an
// asynchronous reset pulse.
module tb_scoreboard_register_file;
  localparam int XLEN  = 64;
  localparam int NREG  = 64;
  localparam int NREAD = 3;
  localparam int AW    = $clog2(NREG);

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  scoreboard_register_file_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) bus();

  scoreboard_register_file #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  // Apply writeback, flush and issue in that order so that the later actions
  // override the earlier ones. This gives issue over flush over writeback.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (bus.wr_en && bus.wr_addr != 0) m_regs[bus.wr_addr] = bus.wr_data;
      if (bus.wr_en) m_busy[bus.wr_addr] = 1'b0;
      if (bus.flush) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      if (bus.issue_en) m_busy[bus.issue_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_port(input logic [AW-1:0] a, output logic [XLEN-1:0] d,
                                   output logic b);
    d = m_regs[a];
    b = m_busy[a];
`ifdef RF_BYPASS_EN
    if (bus.wr_en && bus.wr_addr != 0 && a == bus.wr_addr) begin
      d = bus.wr_data;
      b = bus.issue_en && (bus.issue_addr == bus.wr_addr);
    end
`endif
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    logic [XLEN-1:0] ed;
    logic            eb;
    logic            any;
    int              cnt;
    any = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      exp_port(bus.rd_addr[p*AW +: AW], ed, eb);
      chk("model_rd_data", bus.rd_data[p*XLEN +: XLEN], ed);
      chk("model_rd_busy", 64'(bus.rd_busy[p]), 64'(eb));
      any = any | eb;
    end
    chk("model_stall", 64'(bus.stall), 64'(any));
    cnt = 0;
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    chk("model_busy_count", 64'(bus.busy_count), 64'(cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    bus.rd_addr[0*AW +: AW] = AW'(a0);
    bus.rd_addr[1*AW +: AW] = AW'(a1);
    bus.rd_addr[2*AW +: AW] = AW'(a2);
  endtask

  function automatic logic [XLEN-1:0] rdd(input int p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    reset_n = 1'b0;
    idle();
    set_rd(0, 0, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Reset mid-run
    bus.wr_en = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 64'hDEADBEEF;
    bus.issue_en = 1'b1; bus.issue_addr = 6'd7;
    tick();
    idle();
    set_rd(5, 7, 5);
    @(negedge clk);
    chk("pre_reset_data5", rdd(0), 64'hDEADBEEF);
    chk("pre_reset_busy7", 64'(bus.rd_busy[1]), 64'd1);
    chk("pre_reset_count", 64'(bus.busy_count), 64'd1);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("in_reset_data5", rdd(0), 64'd0);
    chk("in_reset_busy7", 64'(bus.rd_busy[1]), 64'd0);
    chk("in_reset_count", 64'(bus.busy_count), 64'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_data5", rdd(0), 64'd0);
    chk("post_reset_stall", 64'(bus.stall), 64'd0);

    // x0 stays zero and never busy
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd0; bus.wr_data = 64'h12345678;
    bus.issue_en = 1'b1; bus.issue_addr = 6'd0;
    set_rd(0, 0, 0);
    tick();
    idle();
    @(negedge clk);
    for (int p = 0; p < NREAD; p++) chk("x0_data", rdd(p), 64'd0);
    chk("x0_busy", 64'(bus.rd_busy), 64'd0);
    chk("x0_count", 64'(bus.busy_count), 64'd0);

    // Scoreboard issue then writeback
    tick();
    bus.issue_en = 1'b1; bus.issue_addr = 6'd10;
    tick();
    idle();
    set_rd(10, 10, 10);
    @(negedge clk);
    chk("sb_busy", 64'(bus.rd_busy[0]), 64'd1);
    chk("sb_stall", 64'(bus.stall), 64'd1);
    chk("sb_count", 64'(bus.busy_count), 64'd1);
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd10; bus.wr_data = 64'hA5A5A5A5;
    tick();
    idle();
    @(negedge clk);
    chk("wb_data", rdd(2), 64'hA5A5A5A5);
    chk("wb_busy", 64'(bus.rd_busy[2]), 64'd0);
    chk("wb_count", 64'(bus.busy_count), 64'd0);

    // Collision: issue + writeback + flush on reg 3, reg 4 busy before
    tick();
    bus.issue_en = 1'b1; bus.issue_addr = 6'd4;
    tick();
    bus.issue_addr = 6'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 6'd3; bus.wr_data = 64'h55;
    bus.flush = 1'b1;
    tick();
    idle();
    set_rd(3, 4, 3);
    @(negedge clk);
    chk("col_busy3", 64'(bus.rd_busy[0]), 64'd1);
    chk("col_data3", rdd(0), 64'h55);
    chk("col_busy4", 64'(bus.rd_busy[1]), 64'd0);
    chk("col_count", 64'(bus.busy_count), 64'd1);

    // Bypass
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd9; bus.wr_data = 64'h1;
    tick();
    bus.wr_data = 64'hCAFEF00D;
    set_rd(9, 9, 9);
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("byp_same_data", rdd(1), 64'hCAFEF00D);
`else
    chk("byp_same_data", rdd(1), 64'h1);
`endif
    chk("byp_same_busy", 64'(bus.rd_busy), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("byp_next_data", rdd(1), 64'hCAFEF00D);

    // Fill the scoreboard, then flush
    tick();
    bus.flush = 1'b1;
    tick();
    idle();
    for (int i = 1; i < NREG; i++) begin
      bus.issue_en = 1'b1; bus.issue_addr = AW'(i);
      tick();
    end
    idle();
    set_rd(9, 10, 3);
    @(negedge clk);
    chk("fill_count", 64'(bus.busy_count), 64'd63);
    tick();
    bus.flush = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("flush_count", 64'(bus.busy_count), 64'd0);
    chk("flush_data9", rdd(0), 64'hCAFEF00D);
    chk("flush_data10", rdd(1), 64'hA5A5A5A5);
    chk("flush_data3", rdd(2), 64'h55);

    // Randomized traffic with one asynchronous reset pulse
    for (int n = 0; n < 3000; n++) begin
      bus.issue_en   = ($urandom_range(0, 3) == 0);
      bus.issue_addr = AW'($urandom_range(0, NREG-1));
      bus.wr_en      = ($urandom_range(0, 2) == 0);
      bus.wr_addr    = AW'($urandom_range(0, NREG-1));
      bus.wr_data    = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) bus.issue_addr = bus.wr_addr;
      bus.flush      = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < NREAD; p++)
        bus.rd_addr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? bus.wr_addr
                                                              : AW'($urandom_range(0, NREG-1));
      if (n == 1500) begin
        #2;
        reset_n = 1'b0;
      end
      tick();
      reset_n = 1'b1;
    end

    idle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised integer register file for the next core generation: XLEN-bit registers, NREG entries, NREAD combinational read ports and one write port. It adds a per-register busy scoreboard for in-flight producers, a pipeline-flush clear, and optional same-cycle write-to-read bypass. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

## Interface
- XLEN, 32, register width in bits
- NREG, 32, register count; power of two, ≥2; AW = clog2(NREG)
- NREAD, 2, number of read ports, ≥1
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_addr  in  NREAD*AW  read addresses; port p at [p*AW +: AW]
- rd_data  out  NREAD*XLEN  read data; port p at [p*XLEN +: XLEN]
- rd_busy  out  NREAD  port p operand has a pending producer
- stall  out  1  OR of rd_busy
- issue_en  in  1  mark issue_addr busy
- issue_addr  in  AW  destination being issued
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- flush  in  1  clear all busy bits
- busy_count  out  clog2(NREG)+1  number of busy registers

## Operation
- Storage: regs[NREG] of XLEN bits, busy[NREG] of 1 bit.
- Register 0 is hardwired zero. Writes to address 0 are dropped, busy[0] is never set, and reads of address 0 return 0 with rd_busy=0.
- Write: when wr_en=1 and wr_addr≠0, regs[wr_addr] ← wr_data at the clock edge.
- Busy next-state, per register r≠0, in this priority order:
  - issue_en=1 and issue_addr=r → 1. A new producer wins over both a simultaneous writeback and flush.
  - otherwise flush=1 → 0.
  - otherwise wr_en=1 and wr_addr=r → 0.
  - otherwise hold.
- Read data: rd_data[p] = regs[rd_addr[p]], combinational, subject to the bypass rule in Configuration.
- Read busy: rd_busy[p] = busy[rd_addr[p]], subject to the bypass rule.
- busy_count: registered popcount of busy, updated in the same edge as busy, so it always equals popcount(busy).
- Any number of read ports may name the same address; each returns the same result.

## Timing
- Reset (reset_n=0, asynchronous): all regs=0, all busy=0, busy_count=0. Consequently rd_data=0, rd_busy=0 and stall=0 for every address.
- Reset deasserted mid-operation discards all in-flight state; the first edge after release behaves as a normal cycle.
- Write latency: wr_data is visible on rd_data from the cycle after the edge (0 cycles when bypassed).
- Issue latency: busy is visible on rd_busy from the cycle after issue_en.
- Writeback with no intervening issue to the same address clears busy at the same edge that the data is written.
- No handshake back-pressure: every strobe is accepted every cycle. stall is advisory to issue logic.

## Configuration
- RF_BYPASS_EN defined:
  - If wr_en=1, wr_addr≠0 and rd_addr[p]=wr_addr, then rd_data[p]=wr_data.
  - In that case rd_busy[p]=0, unless issue_en=1 and issue_addr=wr_addr in the same cycle (then rd_busy[p]=1).
- RF_BYPASS_EN undefined: reads return stored state only. A same-cycle write is invisible until the next cycle, and rd_busy reflects the stored busy bit.

## Test plan
- Reset: drive reset_n=0 mid-run after writing regs[5]=0xDEADBEEF and issuing reg 7 → all rd_data=0, rd_busy=0, busy_count=0 while reset is asserted and after release.
- x0: write 0x12345678 to addr 0 and issue_en with issue_addr=0 → reading addr 0 on all ports gives 0, rd_busy=0, busy_count=0.
- Scoreboard: issue reg 10 → next cycle rd_busy=1, stall=1, busy_count=1; writeback reg 10=0xA5A5A5A5 → next cycle rd_data=0xA5A5A5A5, rd_busy=0, busy_count=0.
- Collision: in the same cycle, issue reg 3, writeback reg 3=0x55 and flush=1, with reg 4 previously busy → reg 3 busy=1 and holds 0x55; reg 4 busy=0; busy_count=1.
- Bypass: read addr 9 on every port while writing 0xCAFEF00D to reg 9 (previously 0x1) → with RF_BYPASS_EN, same-cycle rd_data=0xCAFEF00D and rd_busy=0; without it, rd_data=0x1 that cycle and 0xCAFEF00D the next.
- Parameters: run with XLEN=64, NREG=64, NREAD=3; issue regs 1..63 over consecutive cycles → busy_count=63; then flush → busy_count=0 with register contents unchanged.
